// File: rtl/mau_pkg.sv
// Shared definitions for the MEM-stage memory access unit: load-type
// encodings, FSM state encoding, default timeout and store lane replication.
package mau_pkg;

    localparam int unsigned DEFAULT_TIMEOUT = 16;
    localparam int unsigned XLEN            = 32;

    typedef enum logic [2:0] {
        LD_W  = 3'b000,
        LD_BU = 3'b001,
        LD_B  = 3'b010,
        LD_HU = 3'b011,
        LD_H  = 3'b100
    } ld_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Replicate right-justified store data across the lanes; access size is
    // implied by how many byte enables are set.
    function automatic logic [XLEN-1:0] replicate_wdata(input logic [3:0]      be,
                                                        input logic [XLEN-1:0] wdata);
        logic [2:0] n;
        n = 3'(be[0]) + 3'(be[1]) + 3'(be[2]) + 3'(be[3]);
        case (n)
            3'd1:    return {4{wdata[7:0]}};
            3'd2:    return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load alignment: selects the byte/half lane from a raw bus
// word and zero/sign-extends it according to the load type.
//   word   - raw 32-bit word from memory
//   lane   - byte address bits [1:0]
//   ld_op  - load type (unknown codes behave as a full word load)
//   result - aligned, extended load value
module load_align
    import mau_pkg::*;
(
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      lane,
    input  logic [2:0]      ld_op,
    output logic [XLEN-1:0] result
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = word[{lane, 3'b000} +: 8];
        half_v = lane[1] ? word[31:16] : word[15:0];
        result = word;
        case (ld_op)
            LD_BU:   result = {24'b0, byte_v};
            LD_B:    result = {{24{byte_v[7]}}, byte_v};
            LD_HU:   result = {16'b0, half_v};
            LD_H:    result = {{16{half_v[15]}}, half_v};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data memory access unit. Runs one req/ack bus transaction per
// memory instruction, stalls the pipeline while it is in flight and returns
// aligned load data; a timeout ends transactions that are never acknowledged.
//   clk, reset        - clock, asynchronous active-high reset
//   start/we/addr/be/wdata/ld_op - access request from the MEM stage
//   bus_*             - req/ack data bus (outputs held from registers)
//   stall             - pipeline freeze (combinational)
//   done/rdata/err    - completion pulse, load result, timeout flag
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            we,
    input  logic [XLEN-1:0] addr,
    input  logic [3:0]      be,
    input  logic [XLEN-1:0] wdata,
    input  logic [2:0]      ld_op,
    output logic            bus_req,
    output logic            bus_we,
    output logic [XLEN-1:0] bus_addr,
    output logic [3:0]      bus_be,
    output logic [XLEN-1:0] bus_wdata,
    input  logic            bus_ack,
    input  logic [XLEN-1:0] bus_rdata,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] rdata,
    output logic            err
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e          state;
    state_e          state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [1:0]      lane_q;
    logic [2:0]      ld_op_q;
    logic [XLEN-1:0] align_res;
    logic            accept;
    logic            timeout;

    // A zero byte enable is a null access and never leaves IDLE.
    assign accept  = (state == S_IDLE) && start && (be != 4'b0000);
    assign timeout = (cnt == CNT_LAST);

    load_align u_load_align (
        .word   (bus_rdata),
        .lane   (lane_q),
        .ld_op  (ld_op_q),
        .result (align_res)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_REQ;
            S_REQ:   if (bus_ack || timeout) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode; stall is gated by reset so it drops while reset is held.
    always_comb begin
        bus_req = 1'b0;
        done    = 1'b0;
        stall   = 1'b0;
        case (state)
            S_IDLE:  stall = accept && !reset;
            S_REQ: begin
                bus_req = 1'b1;
                stall   = 1'b1;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Request latch, timeout counter and result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= 4'b0000;
            bus_wdata <= '0;
            lane_q    <= 2'b00;
            ld_op_q   <= 3'b000;
            cnt       <= '0;
            rdata     <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        bus_we    <= we;
                        bus_addr  <= {addr[31:2], 2'b00};
                        bus_be    <= be;
                        bus_wdata <= replicate_wdata(be, wdata);
                        lane_q    <= addr[1:0];
                        ld_op_q   <= ld_op;
                        cnt       <= '0;
                    end
                end
                S_REQ: begin
                    if (bus_ack) begin
                        rdata <= bus_we ? '0 : align_res;
                        err   <= 1'b0;
                    end else if (timeout) begin
                        rdata <= '0;
                        err   <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit: loads of every type and
// lane, stores of every size, timeout, null access and reset mid-transaction.
module tb_mem_access_unit;
    import mau_pkg::*;

    localparam int unsigned TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [2:0]  ld_op;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        stall;
    logic        done;
    logic [31:0] rdata;
    logic        err;

    int checks = 0;
    int errors = 0;

    mem_access_unit #(.TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .we        (we),
        .addr      (addr),
        .be        (be),
        .wdata     (wdata),
        .ld_op     (ld_op),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_be    (bus_be),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata),
        .stall     (stall),
        .done      (done),
        .rdata     (rdata),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check32(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // One complete access. ack_at = cycle (after start) in which the bus acks,
    // 0 = never ack. Inputs change just after posedge, outputs checked at negedge.
    task automatic do_access(input string name, input logic w, input logic [31:0] a,
                             input logic [3:0] b, input logic [31:0] wd, input logic [2:0] op,
                             input int ack_at, input logic [31:0] rbus,
                             input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                             input logic [31:0] exp_rdata, input logic exp_err);
        int cyc;
        int stall_cnt;
        int req_cnt;
        int done_cyc;
        int exp_done;
        stall_cnt = 0;
        req_cnt   = 0;
        done_cyc  = -1;
        exp_done  = (ack_at > 0) ? ack_at + 1 : int'(TIMEOUT) + 1;

        @(posedge clk); #1;
        start = 1'b1; we = w; addr = a; be = b; wdata = wd; ld_op = op;
        bus_ack = 1'b0; bus_rdata = 32'hA5A5_5A5A;
        cyc = 0;
        @(negedge clk);
        check32({name, " stall@0"}, 32'(stall), 32'd1);
        check32({name, " req@0"}, 32'(bus_req), 32'd0);
        if (stall) stall_cnt++;

        while (done_cyc < 0 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            bus_ack   = (cyc == ack_at);
            bus_rdata = (cyc == ack_at) ? rbus : 32'hA5A5_5A5A;
            @(negedge clk);
            if (stall) stall_cnt++;
            if (bus_req) begin
                req_cnt++;
                check32({name, " bus_addr"}, bus_addr, exp_addr);
                check32({name, " bus_wdata"}, bus_wdata, exp_wdata);
                check32({name, " bus_be"}, 32'(bus_be), 32'(b));
                check32({name, " bus_we"}, 32'(bus_we), 32'(w));
            end
            if (done) begin
                done_cyc = cyc;
                check32({name, " rdata"}, rdata, exp_rdata);
                check32({name, " err"}, 32'(err), 32'(exp_err));
                check32({name, " stall@done"}, 32'(stall), 32'd0);
            end
        end
        check32({name, " done_cycle"}, 32'(done_cyc), 32'(exp_done));
        check32({name, " stall_cycles"}, 32'(stall_cnt), 32'(exp_done));
        check32({name, " req_cycles"}, 32'(req_cnt), 32'(exp_done - 1));

        @(posedge clk); #1;
        start = 1'b0; bus_ack = 1'b0;
        @(negedge clk);
        check32({name, " done_pulse"}, 32'(done), 32'd0);
        check32({name, " rdata_hold"}, rdata, exp_rdata);
        check32({name, " err_hold"}, 32'(err), 32'(exp_err));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0;
        ld_op = '0; bus_ack = 1'b0; bus_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check32("rst bus_req", 32'(bus_req), 32'd0);
        check32("rst stall", 32'(stall), 32'd0);
        check32("rst done", 32'(done), 32'd0);
        check32("rst err", 32'(err), 32'd0);
        check32("rst bus_addr", bus_addr, 32'd0);
        check32("rst bus_wdata", bus_wdata, 32'd0);
        check32("rst bus_be", 32'(bus_be), 32'd0);
        check32("rst bus_we", 32'(bus_we), 32'd0);
        check32("rst rdata", rdata, 32'd0);
        reset = 1'b0;

        //        name   we    addr          be       wdata         op      ack rbus          bus_addr      bus_wdata     rdata         err
        do_access("LB",  1'b0, 32'h0000_1003, 4'b1000, 32'h0,        3'b010, 2, 32'h80FF_FFFF, 32'h0000_1000, 32'h0,        32'hFFFF_FF80, 1'b0);
        do_access("SH",  1'b1, 32'h0000_2002, 4'b1100, 32'h0000_BEEF, 3'b000, 3, 32'h1234_5678, 32'h0000_2000, 32'hBEEF_BEEF, 32'h0,        1'b0);
        do_access("LHU", 1'b0, 32'h0000_0002, 4'b1100, 32'h0,        3'b011, 1, 32'h8001_7FFF, 32'h0000_0000, 32'h0,        32'h0000_8001, 1'b0);
        do_access("LW",  1'b0, 32'h0000_0104, 4'b1111, 32'h0,        3'b000, 1, 32'hDEAD_BEEF, 32'h0000_0104, 32'h0,        32'hDEAD_BEEF, 1'b0);
        do_access("TMO", 1'b0, 32'h0000_0040, 4'b1111, 32'h0,        3'b000, 0, 32'h0,         32'h0000_0040, 32'h0,        32'h0,        1'b1);
        do_access("LH",  1'b0, 32'h0000_0010, 4'b0011, 32'h0,        3'b100, 2, 32'h1234_8001, 32'h0000_0010, 32'h0,        32'hFFFF_8001, 1'b0);
        do_access("LBU", 1'b0, 32'h0000_0021, 4'b0010, 32'h0,        3'b001, 1, 32'h0000_8000, 32'h0000_0020, 32'h0,        32'h0000_0080, 1'b0);
        do_access("SB",  1'b1, 32'h0000_3001, 4'b0010, 32'h1234_56A5, 3'b000, 4, 32'hFFFF_FFFF, 32'h0000_3000, 32'hA5A5_A5A5, 32'h0,        1'b0);
        do_access("SW",  1'b1, 32'h0000_0050, 4'b1111, 32'hCAFE_F00D, 3'b000, 1, 32'hFFFF_FFFF, 32'h0000_0050, 32'hCAFE_F00D, 32'h0,        1'b0);
        do_access("OP7", 1'b0, 32'h0000_0060, 4'b1111, 32'h0,        3'b111, 2, 32'h8000_0001, 32'h0000_0060, 32'h0,        32'h8000_0001, 1'b0);
        do_access("LB0", 1'b0, 32'h0000_0070, 4'b0001, 32'h0,        3'b010, 1, 32'hFFFF_FF7F, 32'h0000_0070, 32'h0,        32'h0000_007F, 1'b0);

        // Null access: be = 0 must produce no stall, request or completion.
        @(posedge clk); #1;
        start = 1'b1; we = 1'b0; addr = 32'h0000_0080; be = 4'b0000; ld_op = 3'b000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check32("null stall", 32'(stall), 32'd0);
            check32("null bus_req", 32'(bus_req), 32'd0);
            check32("null done", 32'(done), 32'd0);
            @(posedge clk); #1;
        end
        start = 1'b0;

        // Reset in the middle of REQ.
        @(posedge clk); #1;
        start = 1'b1; we = 1'b0; addr = 32'h0000_0044; be = 4'b1111; ld_op = 3'b000;
        @(posedge clk); #1;
        @(negedge clk);
        check32("mid bus_req", 32'(bus_req), 32'd1);
        #1 reset = 1'b1;
        #1;
        check32("rstmid bus_req", 32'(bus_req), 32'd0);
        check32("rstmid stall", 32'(stall), 32'd0);
        check32("rstmid done", 32'(done), 32'd0);
        check32("rstmid err", 32'(err), 32'd0);
        check32("rstmid rdata", rdata, 32'd0);
        check32("rstmid bus_addr", bus_addr, 32'd0);
        start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;

        do_access("POST", 1'b0, 32'h0000_0046, 4'b1100, 32'h0, 3'b100, 2, 32'h9ABC_1234, 32'h0000_0044, 32'h0, 32'hFFFF_9ABC, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Multi-cycle data-memory access unit in the MEM stage, directly downstream of the byte-enable generator. It takes the stage's access request (address, store data, 4-bit byte enable, load type) and runs one req/ack transaction on the data bus. It stalls the pipeline while the transaction is in flight, then returns load data aligned and zero/sign-extended. A timeout counter ends transactions the bus never acknowledges.

## Interface
- TIMEOUT, 16: maximum cycles in REQ waiting for `bus_ack`; range 2..255.
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  MEM stage holds a memory instruction; held high until `done`.
- we  in  1  1 = store, 0 = load.
- addr  in  32  byte address; bits [1:0] select lanes.
- be  in  4  byte enable from the byte-enable generator (0001/0010/0100/1000/0011/1100/1111/0000).
- wdata  in  32  store data, right-justified.
- ld_op  in  3  000 LW, 001 LBU, 010 LB, 011 LHU, 100 LH; other codes behave as LW.
- bus_req  out  1  transaction request.
- bus_we  out  1  write strobe qualifier.
- bus_addr  out  32  word address {addr[31:2],2'b00}.
- bus_be  out  4  latched byte enable.
- bus_wdata  out  32  lane-replicated store data.
- bus_ack  in  1  completion; `bus_rdata` valid in the same cycle.
- bus_rdata  in  32  raw word.
- stall  out  1  freeze pipeline.
- done  out  1  one-cycle completion pulse.
- rdata  out  32  aligned, extended load result; valid while `done`=1.
- err  out  1  timeout flag; valid with `done`.

## Operation
- States: IDLE, REQ, DONE.
- IDLE
  - `start`=1 and `be`≠0: latch `addr`, `we`, `be`, `ld_op`, and replicated `wdata`; clear the counter; go to REQ.
  - `start`=1 and `be`=0: null access. No stall, no bus activity, no `done`; stay in IDLE.
- REQ
  - `bus_req`=1. All bus outputs are held stable from registers.
  - The counter increments each cycle without ack.
  - `bus_ack`=1: register the extracted load data (0 for stores); `err`=0; go to DONE.
  - No ack and counter = TIMEOUT-1: `rdata`=0; `err`=1; go to DONE.
  - Ack in the timeout cycle counts as success.
- DONE
  - `done`=1, `stall`=0; the pipeline advances on this edge.
  - Always returns to IDLE. `start` is ignored here, so one instruction produces exactly one transaction.
- `stall` = (IDLE & start & be≠0) | REQ. This is combinational, so it is high in the cycle `start` arrives.
- Store replication, chosen by the popcount of `be`:
  - 1 bit: {4{wdata[7:0]}}
  - 2 bits: {2{wdata[15:0]}}
  - 4 bits: wdata
- Load extraction:
  - Byte lane = addr[1:0].
  - Half lane = addr[1] (0 → [15:0], 1 → [31:16]).
  - LB/LH sign-extend to 32 bits; LBU/LHU zero-extend; LW passes the word through.
- Reset in any state: go to IDLE immediately. `bus_req`, `stall`, `done`, and `err` drop asynchronously, and the in-flight transaction is abandoned.

## Timing
- Reset values:
  - `bus_req`, `bus_we`, `stall`, `done`, `err` = 0.
  - `bus_addr`, `bus_wdata`, `rdata` = 0.
  - `bus_be` = 0000.
  - State = IDLE; counter = 0.
- Latency: `start` at cycle 0 → `bus_req` from cycle 1.
  - Ack at cycle k (k≥1) → `done` at cycle k+1.
  - Minimum total: 3 cycles (2 stalled).
- Timeout: `bus_req` is high for exactly TIMEOUT cycles, then `done`/`err` in the next cycle.
- `bus_req` falls in the cycle after ack; the bus must not ack while `bus_req`=0.
- `rdata` and `err` are registered and hold their values until the next transaction completes.

## Structure
- Package `mau_pkg`:
  - `ld_op` encodings (LD_W, LD_BU, LD_B, LD_HU, LD_H).
  - State encoding (S_IDLE, S_REQ, S_DONE).
  - Default TIMEOUT.
- Sub-module `load_align`: combinational raw word + addr[1:0] + ld_op → 32-bit result. It is reused by any future cache path.
- The counter is ceil(log2(TIMEOUT)) bits wide.

## Test plan
- LB: addr=0x1003, be=1000, bus_rdata=0x80FF_FFFF, ack after 2 cycles → `done` with `rdata`=0xFFFF_FF80 and `err`=0; `stall` high for 3 cycles.
- SH: addr=0x2002, be=1100, wdata=0x0000_BEEF → `bus_addr`=0x2000, `bus_wdata`=0xBEEF_BEEF, `bus_be`=1100, `bus_we`=1, held stable until ack.
- LHU: addr=0x0002, bus_rdata=0x8001_7FFF, ack at cycle 1 → `rdata`=0x0000_8001; minimum 3-cycle latency.
- No ack with TIMEOUT=16 → `bus_req` high for exactly 16 cycles, then `done`=1, `err`=1, `rdata`=0.
- `start` with be=0000 → `stall`, `bus_req`, and `done` stay 0. Separately, reset asserted mid-REQ → `bus_req` and `stall` drop immediately; after release the next `start` runs cleanly.
